// File: rtl/uart_cmd_ctrl_if.sv
// UART byte link and sample-memory read port seen by the command sequencer.
// master = sequencer side, slave = UART_com / sample memory side.
interface uart_cmd_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_rdy;
  logic              tx_busy;
  logic              trans_en;
  logic [7:0]        data_out;
  logic [ADDR_W-1:0] mem_base;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;

  modport master (
    input  rx_data, rx_rdy, tx_busy, mem_base, mem_rd_data,
    output trans_en, data_out, mem_rd_en, mem_addr
  );

  modport slave (
    output rx_data, rx_rdy, tx_busy, mem_base, mem_rd_data,
    input  trans_en, data_out, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses opcode/argument frames from UART_com, drives the
// trigger configuration and arm pulse, and streams sample memory back out.
//
// state      | meaning
// IDLE       | waiting for an opcode byte
// GET_ARGS   | collecting argument bytes, idle timeout running
// EXEC       | one cycle: perform action, load response or read counter
// TX_ISSUE   | wait for tx_busy=0, then strobe trans_en once
// TX_WAIT_HI | wait for transmitter to report busy
// TX_WAIT_LO | wait for transmitter to finish; next read byte or done
// RD_REQ     | mem_rd_en strobe with mem_addr
// RD_WAIT    | capture mem_rd_data into data_out
module uart_cmd_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               input_clk,
  input  logic               reset,
  uart_cmd_ctrl_if.master    bus,
  output logic               arm,
  output logic [7:0]         trig_mask,
  output logic [7:0]         trig_value,
  input  logic [7:0]         status_in,
  output logic               busy,
  output logic               rx_overrun
);

  localparam logic [7:0] OP_ARM    = 8'h01;
  localparam logic [7:0] OP_SET    = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;
  localparam logic [7:0] ACK_ARM   = 8'hA1;
  localparam logic [7:0] ACK_SET   = 8'hA2;
  localparam logic [7:0] NAK       = 8'hEE;

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ARGS, EXEC, TX_ISSUE, TX_WAIT_HI, TX_WAIT_LO, RD_REQ, RD_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        arg0_q, arg0_d;
  logic [7:0]        arg1_q, arg1_d;
  logic              arg_idx_q, arg_idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_out_q, data_out_d;
  logic [7:0]        trig_mask_q, trig_mask_d;
  logic [7:0]        trig_value_q, trig_value_d;
  logic              ovr_q, ovr_d;
  logic              start_frame;
  logic              arm_o;
  logic              trans_en_o;
  logic              mem_rd_en_o;

  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      arg0_q       <= '0;
      arg1_q       <= '0;
      arg_idx_q    <= 1'b0;
      tmo_q        <= '0;
      rd_cnt_q     <= '0;
      addr_q       <= '0;
      data_out_q   <= '0;
      trig_mask_q  <= '0;
      trig_value_q <= '0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      arg_idx_q    <= arg_idx_d;
      tmo_q        <= tmo_d;
      rd_cnt_q     <= rd_cnt_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      trig_mask_q  <= trig_mask_d;
      trig_value_q <= trig_value_d;
      ovr_q        <= ovr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    arg0_d       = arg0_q;
    arg1_d       = arg1_q;
    arg_idx_d    = arg_idx_q;
    tmo_d        = tmo_q;
    rd_cnt_d     = rd_cnt_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    trig_mask_d  = trig_mask_q;
    trig_value_d = trig_value_q;
    ovr_d        = ovr_q;
    start_frame  = 1'b0;
    arm_o        = 1'b0;
    trans_en_o   = 1'b0;
    mem_rd_en_o  = 1'b0;

    if (bus.rx_rdy && (state_q != IDLE) && (state_q != GET_ARGS)) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.rx_rdy) start_frame = 1'b1;
      end
      GET_ARGS: begin
        // A byte landing on the timeout cycle opens a fresh frame.
        if (tmo_q == '0) begin
          state_d = IDLE;
          if (bus.rx_rdy) start_frame = 1'b1;
        end else if (bus.rx_rdy) begin
          tmo_d = TMO_LOAD;
          if (!arg_idx_q) begin
            arg0_d    = bus.rx_data;
            arg_idx_d = 1'b1;
          end else begin
            arg1_d  = bus.rx_data;
            state_d = EXEC;
          end
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      EXEC: begin
        state_d = TX_ISSUE;
        case (opcode_q)
          OP_ARM: begin
            arm_o      = 1'b1;
            data_out_d = ACK_ARM;
          end
          OP_SET: begin
            trig_mask_d  = arg0_q;
            trig_value_d = arg1_q;
            data_out_d   = ACK_SET;
          end
          OP_READ: begin
            if ({arg0_q, arg1_q} == 16'h0000) begin
              state_d = IDLE;
            end else begin
              rd_cnt_d = {arg0_q, arg1_q};
              addr_d   = bus.mem_base;
              state_d  = RD_REQ;
            end
          end
          OP_STATUS: begin
            data_out_d = status_in;
            ovr_d      = 1'b0;
          end
          default: data_out_d = NAK;
        endcase
      end
      RD_REQ: begin
        mem_rd_en_o = 1'b1;
        state_d     = RD_WAIT;
      end
      RD_WAIT: begin
        data_out_d = bus.mem_rd_data;
        state_d    = TX_ISSUE;
      end
      TX_ISSUE: begin
        if (!bus.tx_busy) begin
          trans_en_o = 1'b1;
          state_d    = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (bus.tx_busy) state_d = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if ((opcode_q == OP_READ) && (rd_cnt_q > 16'd1)) begin
            rd_cnt_d = rd_cnt_q - 16'd1;
            addr_d   = addr_q + ADDR_W'(1);
            state_d  = RD_REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      opcode_d  = bus.rx_data;
      arg_idx_d = 1'b0;
      tmo_d     = TMO_LOAD;
      if ((bus.rx_data == OP_SET) || (bus.rx_data == OP_READ)) state_d = GET_ARGS;
      else                                                     state_d = EXEC;
    end
  end

  assign bus.trans_en  = trans_en_o;
  assign bus.data_out  = data_out_q;
  assign bus.mem_rd_en = mem_rd_en_o;
  assign bus.mem_addr  = addr_q;
  assign arm           = arm_o;
  assign trig_mask     = trig_mask_q;
  assign trig_value    = trig_value_q;
  assign busy          = (state_q != IDLE);
  assign rx_overrun    = ovr_q;

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART link (UART_com) and the logic-analyzer core.
- Parses opcode/argument frames from the receive byte stream and updates trigger configuration.
- Pulses arm and streams sample memory back out over the transmitter.
- Owns the transmit side: it is the only driver of trans_en/data_out and obeys tx_busy.

Parameters:
ADDR_W, 12, sample-memory address width
TIMEOUT_CYCLES, 1000000, max idle cycles between bytes of one frame before the frame is discarded

Ports:
input_clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_data  in  8  received byte (UART_com data_received)
rx_rdy  in  1  one-cycle pulse, rx_data valid (UART_com data_rdy)
tx_busy  in  1  transmitter busy
trans_en  out  1  one-cycle transmit strobe
data_out  out  8  byte to transmit
arm  out  1  one-cycle arm pulse to capture core
trig_mask  out  8  trigger channel mask
trig_value  out  8  trigger match value
status_in  in  8  capture-core status byte
mem_base  in  ADDR_W  first address for READ
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
busy  out  1  high whenever state != IDLE
rx_overrun  out  1  sticky: a byte arrived while not accepting

Behaviour:
Reset (reset=0, async):
- All outputs 0; state IDLE; counters 0.

Opcodes (byte 0 of frame):
- 0x01 ARM: 0 args. Pulse arm 1 cycle in EXEC, then transmit 0xA1.
- 0x02 SET_TRIG: 2 args, mask then value. In EXEC, trig_mask/trig_value load together in the same cycle, then transmit 0xA2.
- 0x03 READ: 2 args, len_hi then len_lo (16-bit length L). Stream L bytes from mem[(mem_base+i) mod 2^ADDR_W], i=0..L-1. No trailing ack. L=0 sends nothing and returns to IDLE.
- 0x04 STATUS: 0 args. Transmit status_in sampled in EXEC, then clear rx_overrun.
- Any other opcode: transmit 0xEE (NAK); no other side effects.

FSM states: IDLE, GET_ARGS, EXEC, TX_ISSUE, TX_WAIT_HI, TX_WAIT_LO, RD_REQ, RD_WAIT.
- IDLE: on rx_rdy latch opcode. Go to GET_ARGS if its arg count > 0, else EXEC.
- GET_ARGS: each rx_rdy stores the next arg; after the last arg go to EXEC.
  - Timeout counter resets on every rx_rdy.
  - On reaching TIMEOUT_CYCLES, discard the frame and go to IDLE with no response.
- EXEC: one cycle. Perform the action; load the response byte into data_out, or init the read counter for READ; go to TX_ISSUE or RD_REQ.
- RD_REQ: mem_rd_en=1 for one cycle with mem_addr set; go to RD_WAIT.
- RD_WAIT: next cycle capture mem_rd_data into data_out; go to TX_ISSUE.
- TX_ISSUE: wait while tx_busy=1. When tx_busy=0, assert trans_en for exactly one cycle; go to TX_WAIT_HI.
- TX_WAIT_HI: wait for tx_busy=1, then go to TX_WAIT_LO.
- TX_WAIT_LO: wait for tx_busy=0.
  - If READ has bytes remaining: increment address/count and go to RD_REQ.
  - Otherwise go to IDLE.
- data_out holds stable from TX_ISSUE until the exit from TX_WAIT_LO.

Rules:
- trans_en is never high in two consecutive cycles and never asserted while tx_busy=1.
- rx_rdy in any state other than IDLE/GET_ARGS: byte dropped, rx_overrun set to 1.
  - If this coincides with the STATUS clear, the clear wins.
- rx_rdy in the same cycle as the timeout fires: byte taken as the new opcode in IDLE, no overrun.
- Address arithmetic is modulo 2^ADDR_W; the 16-bit length counter never wraps.
- Reset asserted mid-frame or mid-stream: immediate abort, all outputs 0. trig_mask/trig_value also return to 0.
- Latency: from rx_rdy of the last frame byte to trans_en is 2 cycles (EXEC, TX_ISSUE) with tx_busy=0. READ adds 2 cycles (RD_REQ, RD_WAIT).

Test Plan:
- Rx 0x02,0x0F,0x05 -> trig_mask=0x0F and trig_value=0x05 updated in the same cycle; one trans_en with data_out=0xA2; busy falls after tx_busy falls.
- Rx 0x01 -> arm high exactly 1 cycle; trans_en 2 cycles after rx_rdy with data_out=0xA1.
- mem_base=0xFFE, mem preloaded mem[0xFFE]=0x11, mem[0xFFF]=0x22, mem[0x000]=0x33; rx 0x03,0x00,0x03 -> mem_addr 0xFFE,0xFFF,0x000. Bytes 0x11,0x22,0x33 transmitted in order, one trans_en per tx_busy cycle. Also rx 0x03,0x00,0x00 -> no trans_en, back to IDLE.
- Rx 0x02,0x0F, then silence for TIMEOUT_CYCLES (set 50) -> no response, trig regs unchanged. A following 0x04 with status_in=0x5A -> transmits 0x5A.
- During a 4-byte READ inject rx_rdy -> byte ignored, stream completes, rx_overrun=1. Then 0x04 -> status sent, rx_overrun=0. Then 0x7F -> transmits 0xEE.
- Pull reset low during the 2nd byte of a READ while tx_busy=1 -> outputs 0 asynchronously. After release, state is IDLE and a new 0x01 command works normally.
